// File: rtl/acc_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// acc_mult_ctrl_if
//   Bundles the front-panel launch inputs, the ALU carry feedback and the
//   datapath control outputs of acc_mult_ctrl.
//   master : front panel / datapath side (drives start, operands, alu_cout)
//   slave  : the sequencer (drives op_a, strobes, mux/opcode, status)
// ---------------------------------------------------------------------------
interface acc_mult_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [CNT_W-1:0] b_in;
    logic             alu_cout;
    logic [WIDTH-1:0] op_a;
    logic             acc_clr;
    logic             acc_ld;
    logic             mux_sel;
    logic [1:0]       alu_op;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, a_in, b_in, alu_cout,
        input  op_a, acc_clr, acc_ld, mux_sel, alu_op, busy, done, ovf
    );

    modport slave (
        input  start, a_in, b_in, alu_cout,
        output op_a, acc_clr, acc_ld, mux_sel, alu_op, busy, done, ovf
    );
endinterface

// File: rtl/acc_mult_ctrl.sv
// ---------------------------------------------------------------------------
// acc_mult_ctrl
//   Sequencer for the accumulator datapath. Computes A*B by clearing the
//   accumulator and then adding A to it B times.
//   Ports:
//     clk  - system clock, all state changes on posedge
//     clr  - synchronous active-high reset, overrides everything
//     bus  - acc_mult_ctrl_if.slave:
//              in : start, a_in, b_in, alu_cout
//              out: op_a, acc_clr, acc_ld, mux_sel, alu_op, busy, done, ovf
// ---------------------------------------------------------------------------
module acc_mult_ctrl #(
    parameter int         WIDTH   = 16,
    parameter int         CNT_W   = 8,
    parameter logic [1:0] ALU_ADD = 2'b00
) (
    input  logic            clk,
    input  logic            clr,
    acc_mult_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic             ovf_q,   ovf_d;

    logic       acc_clr, acc_ld, mux_sel, busy, done;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state plus Moore output decode from the registered state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        ovf_d   = ovf_q;
        acc_clr = 1'b0;
        acc_ld  = 1'b0;
        mux_sel = 1'b0;
        alu_op  = ALU_ADD;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    op_a_d  = bus.a_in;
                    cnt_d   = bus.b_in;
                    ovf_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                acc_clr = 1'b1;
                busy    = 1'b1;
                state_d = (cnt_q == '0) ? S_DONE : S_ADD;
            end
            S_ADD: begin
                acc_ld  = 1'b1;
                mux_sel = 1'b1;
                busy    = 1'b1;
                // Only entered with cnt_q >= 1, so the decrement cannot wrap.
                cnt_d   = cnt_q - 1'b1;
                ovf_d   = ovf_q | bus.alu_cout;
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.op_a    = op_a_q;
    assign bus.acc_clr = acc_clr;
    assign bus.acc_ld  = acc_ld;
    assign bus.mux_sel = mux_sel;
    assign bus.alu_op  = alu_op;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_acc_mult_ctrl.sv
module tb_acc_mult_ctrl;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    acc_mult_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    acc_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ALU_ADD(2'b00)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Behavioural accumulator datapath: clear, or add op_a when loaded.
    logic [WIDTH-1:0] acc_m;
    logic [WIDTH:0]   sum_m;
    assign sum_m        = {1'b0, acc_m} + {1'b0, bus.op_a};
    assign bus.alu_cout = bus.acc_ld & sum_m[WIDTH];

    always @(posedge clk) begin
        if (clr || bus.acc_clr) acc_m <= '0;
        else if (bus.acc_ld && bus.mux_sel) acc_m <= sum_m[WIDTH-1:0];
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        int               b;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: accumulates per-run strobe counts; on done, pops and compares.
    int  ld_cnt = 0, clr_cnt = 0, busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (clr) begin
            ld_cnt = 0; clr_cnt = 0; busy_cnt = 0; prev_done = 1'b0;
        end else begin
            if (bus.busy)    busy_cnt++;
            if (bus.acc_clr) clr_cnt++;
            if (bus.acc_ld) begin
                ld_cnt++;
                if (bus.mux_sel !== 1'b1 || bus.alu_op !== 2'b00)
                    chk("add_ctrl", {bus.mux_sel, bus.alu_op}, 3'b100);
            end
            if (bus.done) begin
                n_done++;
                chk("done_single_pulse", prev_done, 0);
                chk("done_busy_low", bus.busy, 0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    longint prod;
                    e    = q.pop_front();
                    prod = longint'(e.a) * e.b;
                    chk("acc_result", acc_m, prod % 65536);
                    chk("ovf",        bus.ovf, (prod > 65535) ? 1 : 0);
                    chk("op_a_held",  bus.op_a, e.a);
                    chk("ld_cycles",  ld_cnt, e.b);
                    chk("clr_cycles", clr_cnt, 1);
                    chk("busy_cycles", busy_cnt, e.b + 1);
                end
                ld_cnt = 0; clr_cnt = 0; busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("wait_idle_timeout", k, 0);
    endtask

    // Issue one run; returns at the negedge after the accepting edge, with
    // operand inputs scrambled to confirm they were latched.
    task automatic launch(input logic [WIDTH-1:0] a, input int b);
        exp_t e;
        wait_idle();
        bus.a_in  = a;
        bus.b_in  = CNT_W'(b);
        bus.start = 1'b1;
        e.a = a; e.b = b;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = WIDTH'($urandom);
        bus.b_in  = CNT_W'($urandom);
    endtask

    initial begin
        int nruns;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        clr       = 1'b1;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_strobes", {bus.acc_clr, bus.acc_ld, bus.mux_sel}, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_op_a", bus.op_a, 0);
        chk("rst_ovf", bus.ovf, 0);
        clr = 1'b0;

        // Basic 3*4, then B=0.
        launch(16'd3, 4);
        launch(16'd7, 0);

        // Start held for 20 edges with B=2: a new run each B+3 cycles.
        wait_idle();
        bus.a_in  = 16'd5;
        bus.b_in  = 8'd2;
        bus.start = 1'b1;
        nruns = (20 + (2 + 3) - 1) / (2 + 3);
        for (int i = 0; i < nruns; i++) begin
            exp_t e;
            e.a = 16'd5; e.b = 2;
            q.push_back(e);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;

        // Overflow on the second add; held after done, cleared by next start.
        launch(16'hFFFF, 2);
        wait_idle();
        chk("ovf_held_idle", bus.ovf, 1);
        chk("op_a_held_idle", bus.op_a, 16'hFFFF);
        launch(16'd1, 1);
        chk("ovf_cleared_on_start", bus.ovf, 0);

        // Mid-run abort after the accumulator has already overflowed.
        launch(16'h4000, 200);
        repeat (6) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        void'(q.pop_back());
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_strobes", {bus.acc_clr, bus.acc_ld, bus.mux_sel, bus.done}, 0);
        chk("abort_ovf", bus.ovf, 0);
        chk("abort_op_a", bus.op_a, 0);
        clr = 1'b0;
        @(negedge clk);
        chk("abort_no_ld", bus.acc_ld, 0);

        // Maximum repeat count.
        launch(16'd1, 255);

        // Randomized runs.
        for (int i = 0; i < 25; i++) begin
            launch(WIDTH'($urandom), (i % 5 == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 12)));
        end

        // Drain.
        begin
            int k = 0;
            while ((q.size() != 0 || bus.busy || bus.done) && k < 5000) begin
                @(negedge clk);
                k++;
            end
            chk("drain_timeout", (k >= 5000) ? 1 : 0, 0);
        end
        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done, 2 + nruns + 2 + 1 + 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
